// File: rtl/smps_pkg.sv
// smps_pkg: shared definitions for the switching-converter PWM blocks.
//   - state_e      : sequencer FSM encoding, visible on o_state
//   - N_DEFAULT    : default width of period/duty/phase counters
//   - DT_W_DEFAULT : default width of the dead-time value
//   - is_active()  : true in states where the carrier runs
package smps_pkg;

    localparam int unsigned N_DEFAULT    = 10;
    localparam int unsigned DT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SOFTSTART = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_e;

    function automatic logic is_active(state_e s);
        return (s == ST_SOFTSTART) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/pwm_carrier.sv
// pwm_carrier: phase counter for the PWM sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   active_i   : sequencer currently in a running state
//   stop_i     : sequencer leaves the running states on this edge
//   period_i   : latched period P (>= 2 whenever active_i is high)
//   count_o    : phase counter c
//   wrap_o     : c is at P-1 and will return to 0 on this edge
//   start_o    : c = 0 while running (period-start pulse)
module pwm_carrier
    import smps_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         active_i,
    input  logic         stop_i,
    input  logic [N-1:0] period_i,
    output logic [N-1:0] count_o,
    output logic         wrap_o,
    output logic         start_o
);

    logic [N-1:0] count_q, count_d;

    assign wrap_o  = active_i && (count_q == period_i - N'(1));
    assign start_o = active_i && (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q + N'(1);
        if (!active_i || stop_i || wrap_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: half-bridge PWM with soft-start, dead time and fault latch.
//   clk, reset      : clock, asynchronous active-high reset
//   i_enable        : run request
//   i_period        : period P in cycles (clamped to >= 2)
//   i_duty          : target high-side window end D (clamped to <= P)
//   i_deadtime      : dead time T in cycles
//   i_ss_step       : soft-start duty increment per period (0 means 1)
//   i_fault         : fault input, forces FAULT
//   i_fault_clr     : fault acknowledge
//   o_hs, o_ls      : registered high-side / low-side gate drives
//   o_state         : FSM state (0 IDLE, 1 SOFTSTART, 2 RUN, 3 FAULT)
//   o_period_start  : high while running with c = 0
//   o_duty_cur      : duty value in use this period
module pwm_sequencer
    import smps_pkg::*;
#(
    parameter int unsigned N    = N_DEFAULT,
    parameter int unsigned DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_enable,
    input  logic [N-1:0]    i_period,
    input  logic [N-1:0]    i_duty,
    input  logic [DT_W-1:0] i_deadtime,
    input  logic [N-1:0]    i_ss_step,
    input  logic            i_fault,
    input  logic            i_fault_clr,
    output logic            o_hs,
    output logic            o_ls,
    output logic [1:0]      o_state,
    output logic            o_period_start,
    output logic [N-1:0]    o_duty_cur
);

    state_e          state_q, state_d;
    logic [N-1:0]    period_q, period_d;
    logic [N-1:0]    target_q, target_d;
    logic [DT_W-1:0] dt_q, dt_d;
    logic [N-1:0]    duty_q, duty_d;
    logic            hs_q, hs_d;
    logic            ls_q, ls_d;

    logic            run_now, run_next;
    logic [N-1:0]    count;
    logic            wrap;
    logic [N-1:0]    period_new, target_new, ss_inc, ss_duty;
    logic [N:0]      ss_sum, cnt_x, dt_x, duty_x;

    assign run_now  = is_active(state_q);
    assign run_next = is_active(state_d);

    pwm_carrier #(.N(N)) u_carrier (
        .clk      (clk),
        .reset    (reset),
        .active_i (run_now),
        .stop_i   (!run_next),
        .period_i (period_q),
        .count_o  (count),
        .wrap_o   (wrap),
        .start_o  (o_period_start)
    );

    // Clamped values that will be latched when the next period begins.
    always_comb begin
        period_new = (i_period < N'(2)) ? N'(2) : i_period;
        target_new = (i_duty > period_new) ? period_new : i_duty;
        ss_inc     = (i_ss_step == '0) ? N'(1) : i_ss_step;
        ss_sum     = {1'b0, duty_q} + {1'b0, ss_inc};
        ss_duty    = (ss_sum > {1'b0, target_new}) ? target_new : ss_sum[N-1:0];
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; fault outranks every other transition
    always_comb begin
        state_d = state_q;
        if (i_fault && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE:      if (i_enable) state_d = ST_SOFTSTART;
                ST_SOFTSTART: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                    end else if (wrap && (ss_duty == target_new)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:       if (!i_enable) state_d = ST_IDLE;
                ST_FAULT:     if (i_fault_clr && !i_fault) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs. Gates are only driven while running now and next, so any
    // exit from the running states drops both gates on the same edge.
    always_comb begin
        cnt_x   = {1'b0, count};
        dt_x    = (N+1)'(dt_q);
        duty_x  = {1'b0, duty_q};
        hs_d    = run_now && run_next && (dt_x <= cnt_x) && (cnt_x < duty_x);
        ls_d    = run_now && run_next && ((duty_x + dt_x) <= cnt_x) && (count < period_q);
        o_state = state_q;
    end

    // Period parameters are captured on the edge where c becomes 0: on
    // entry from IDLE and on every wrap while running.
    always_comb begin
        period_d = period_q;
        target_d = target_q;
        dt_d     = dt_q;
        duty_d   = duty_q;
        if (!run_next) begin
            duty_d = '0;
        end else if (!run_now) begin
            period_d = period_new;
            target_d = target_new;
            dt_d     = i_deadtime;
            duty_d   = '0;
        end else if (wrap) begin
            period_d = period_new;
            target_d = target_new;
            dt_d     = i_deadtime;
            duty_d   = (state_q == ST_RUN) ? target_new : ss_duty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            target_q <= '0;
            dt_q     <= '0;
            duty_q   <= '0;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            period_q <= period_d;
            target_q <= target_d;
            dt_q     <= dt_d;
            duty_q   <= duty_d;
            hs_q     <= hs_d;
            ls_q     <= ls_d;
        end
    end

    assign o_hs       = hs_q;
    assign o_ls       = ls_q;
    assign o_duty_cur = duty_q;

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter N, default 10: width of period, duty and phase counters.
REQ-002 Parameter DT_W, default 6: width of dead-time value.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_enable  input  1  high = run converter, low = stop.
REQ-006 i_period  input  N  switching period P in clk cycles.
REQ-007 i_duty  input  N  target high-side on-window end D in cycles.
REQ-008 i_deadtime  input  DT_W  dead time T in cycles.
REQ-009 i_ss_step  input  N  soft-start duty increment per period.
REQ-010 i_fault  input  1  high = overcurrent/overvoltage fault.
REQ-011 i_fault_clr  input  1  fault acknowledge.
REQ-012 o_hs  output  1  high-side gate drive.
REQ-013 o_ls  output  1  low-side gate drive.
REQ-014 o_state  output  2  FSM state: 0 IDLE, 1 SOFTSTART, 2 RUN, 3 FAULT.
REQ-015 o_period_start  output  1  one-cycle pulse when phase counter c = 0.
REQ-016 o_duty_cur  output  N  duty value in use this period.

Function
REQ-017 Phase counter c SHALL count 0..P-1 while state is SOFTSTART or RUN, then wrap to 0; c SHALL be held at 0 in IDLE and FAULT.
REQ-018 P, target D and T SHALL be latched only at c = 0; mid-period input changes SHALL take effect at the next period.
REQ-019 Latched P < 2 SHALL be clamped to 2; target D > P SHALL be clamped to P.
REQ-020 o_hs SHALL be registered high the cycle after c satisfies T <= c < duty_cur, and low otherwise.
REQ-021 o_ls SHALL be registered high the cycle after c satisfies duty_cur+T <= c < P, and low otherwise.
REQ-022 duty_cur+T SHALL be computed at N+1 bits; no overflow wrap.
REQ-023 o_hs and o_ls SHALL never both be high; if duty_cur <= T, o_hs SHALL stay low the whole period.
REQ-024 IDLE -> SOFTSTART when i_enable = 1 and i_fault = 0; duty_cur SHALL be 0 on entry.
REQ-025 In SOFTSTART, at each wrap to c = 0, duty_cur SHALL become min(duty_cur + step, target D), where step = 1 if i_ss_step = 0.
REQ-026 SOFTSTART -> RUN on the clock edge at which duty_cur equals target D.
REQ-027 In RUN, duty_cur SHALL load latched target D at each c = 0.
REQ-028 If target D is lowered below duty_cur during SOFTSTART, duty_cur SHALL take the new D at the next c = 0 and the FSM SHALL enter RUN.
REQ-029 i_enable = 0 in SOFTSTART or RUN SHALL force IDLE on the next edge, with o_hs = o_ls = 0 from that edge.
REQ-030 i_fault = 1 in any state except FAULT SHALL force FAULT on the next edge, with o_hs = o_ls = 0 from that edge.
REQ-031 Fault SHALL take priority over every other transition when asserted together with enable, disable or period wrap.
REQ-032 FAULT -> IDLE only when i_fault_clr = 1 and i_fault = 0 in the same cycle; i_enable SHALL be ignored while in FAULT.
REQ-033 o_period_start SHALL be high only in SOFTSTART or RUN cycles where c = 0.

Reset
REQ-034 Reset assertion SHALL immediately force: state IDLE, c = 0, duty_cur = 0, o_hs = 0, o_ls = 0, o_period_start = 0, and latched P/D/T = 0.
REQ-035 After reset deassertion, the first transition SHALL require a clocked i_enable = 1.

Structure
REQ-036 The state encoding and the default widths N and DT_W SHALL live in a shared package named smps_pkg.
REQ-037 The phase counter with wrap and period-start logic SHALL be one sub-module, pwm_carrier; FSM, soft-start and gate compare logic SHALL stay in pwm_sequencer.

Verification
REQ-038 Test 1: P=10, D=6, T=2, step=6 enable -> RUN after first wrap; o_hs high 4 cycles (c 2..5), o_ls high 2 cycles (c 8..9) per period.
REQ-039 Test 2: P=10, D=6, T=2, step=2 -> duty_cur 0,2,4,6 at successive wraps; o_state = RUN when duty_cur reaches 6.
REQ-040 Test 3: D=2, T=3 -> o_hs never high, o_ls high for c 5..9; 10000-cycle check that o_hs and o_ls are never both high.
REQ-041 Test 4: i_fault pulse at c=4 in RUN -> both gates low next edge, o_state = 3; i_fault_clr with i_fault=1 -> stays in FAULT; i_fault_clr with i_fault=0 -> IDLE.
REQ-042 Test 5: i_duty 6 -> 3 at c=4 -> current period keeps D=6, next period uses D=3; i_period = 1 -> period clamped to 2.
REQ-043 Test 6: async reset mid-RUN, between clock edges -> all outputs 0 and o_state = 0 before the next edge; i_enable held high -> SOFTSTART on first edge after release.
